lcd_time_display: RTL
=====================

# lcd_time_display

Consumer end of the time-of-day interface: takes the binary `hour`/`min`/`sec` counters produced by the clock block and drives an HD44780-compatible character LCD in 8-bit, write-only mode. After power-up initialisation it repeatedly rewrites line 1, columns 0–7, as ASCII `HH:MM:SS`. The block sits between the clock counter and the LCD pins at board top level.

## Interface
- `PWRUP_CYC`, default 1080000: idle cycles after reset before the first command (20 ms at 54 MHz).
- `E_HIGH_CYC`, default 27: `lcd_e` high width in cycles (500 ns).
- `CMD_WAIT_CYC`, default 2700: post-E wait for normal commands and characters (50 µs).
- `CLR_WAIT_CYC`, default 108000: post-E wait after Clear Display (2 ms).
- `clk` in 1: system clock (54 MHz). One clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `hour` in 5: binary hour, 0–23 nominal.
- `min` in 6: binary minute, 0–59 nominal.
- `sec` in 6: binary second, 0–59 nominal.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_e` out 1: enable strobe.
- `lcd_data` out 8: LCD data bus.
- `init_done` out 1: high once the init sequence has completed; stays high until reset.
- `frame_done` out 1: one-cycle pulse after the 8th character of each refresh completes its wait.

## Operation
- Reset values: `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `lcd_data`=8'h00, `init_done`=0, `frame_done`=0. The state is PWRUP, and all counters are 0.
- State machine: PWRUP → INIT → ADDR → CHAR → ADDR …
  - PWRUP: counts `PWRUP_CYC` cycles, then enters INIT.
  - INIT: issues 4 command transactions in this order: 8'h38 (function set), 8'h0C (display on), 8'h01 (clear, followed by `CLR_WAIT_CYC`), 8'h06 (entry mode). After the 4th transaction, `init_done` rises and the machine enters ADDR.
  - ADDR: on entry, latches a snapshot of `hour`, `min`, `sec`. It then issues command 8'h80 (DDRAM address 0) and enters CHAR with index 0.
  - CHAR: issues 8 data transactions (`lcd_rs`=1) from the snapshot: H tens, H ones, 8'h3A, M tens, M ones, 8'h3A, S tens, S ones. After index 7, `frame_done` pulses and the machine returns to ADDR.
- Digit rule: tens = v/10 and ones = v%10, computed on the snapshot. The ASCII code is 8'h30 + digit. Out-of-range inputs are not clamped: 63 displays as `63`.
- Input changes during a frame do not affect that frame. Each frame is tear-free.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. After release, the full PWRUP and INIT sequence repeats.

## Timing
- A transaction is exactly 1 + `E_HIGH_CYC` + W cycles, where W is `CMD_WAIT_CYC`, or `CLR_WAIT_CYC` for 8'h01:
  - Setup cycle: `lcd_rs`/`lcd_data` change and `lcd_e`=0.
  - Strobe: `lcd_e`=1 for `E_HIGH_CYC` cycles.
  - Hold/wait: `lcd_e`=0 for W cycles. `lcd_rs`/`lcd_data` hold their values for the whole transaction.
- Consecutive transactions are back-to-back, with no extra cycles.
- First `lcd_e` rise occurs at cycle `PWRUP_CYC`+1 after reset release.
- `init_done` rises in the cycle after the last INIT wait cycle. The snapshot is taken in that same cycle.
- Frame period is 9 × (1 + `E_HIGH_CYC` + `CMD_WAIT_CYC`) cycles. `frame_done` is asserted in the last wait cycle of character 7.
- `lcd_e` never glitches: it is a registered output.

## Structure
- Shared package `lcd_pkg`:
  - command constants `LCD_FUNC_SET`=8'h38, `LCD_DISP_ON`=8'h0C, `LCD_CLEAR`=8'h01, `LCD_ENTRY`=8'h06, `LCD_DDRAM0`=8'h80, `ASCII_0`=8'h30, `ASCII_COLON`=8'h3A;
  - state enum.
- Sub-module `lcd_bus_write` owns one transaction.
  - Inputs: `start`, `rs`, `data`, `long_wait`.
  - Outputs: `lcd_*` pins and `done` (a one-cycle pulse in the last wait cycle).
  - The top-level FSM sequences it and formats the digits.

## Test plan
Use small parameters: `PWRUP_CYC`=10, `E_HIGH_CYC`=2, `CMD_WAIT_CYC`=4, `CLR_WAIT_CYC`=8.
- Reset release, inputs 0 → no `lcd_e` for 10 cycles. Then 4 strobes with `lcd_rs`=0 and data 38, 0C, 01, 06. A gap of 8 follows 01. `init_done` rises after the 06 wait.
- hour=12, min=34, sec=56 held → after 80, data strobes with `lcd_rs`=1 and bytes 31 32 3A 33 34 3A 35 36. `frame_done` pulses once. Frame period = 63 cycles.
- Change sec 56→57 during character 3 → current frame still shows `36`; next frame shows `37`.
- hour=23, min=59, sec=59, then 0/0/0 → frames show `23:59:59`, then `00:00:00` (30 30 3A 30 30 3A 30 30).
- Inputs sec=63, hour=31 → bytes 36 33 and 33 31; no hang.
- Assert reset during the strobe of character 4 → `lcd_e`, `lcd_data`, and `init_done` go to 0 immediately. After release, the full init sequence repeats.

Source files
------------

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg: HD44780 command constants, state enums, time-digit formatting. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DDRAM0   = 8'h80;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_ADDR, ST_CHAR} lcd_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_WAIT} bus_phase_e;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return LCD_FUNC_SET;
      3'd1:    return LCD_DISP_ON;
      3'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] ascii_tens(input logic [5:0] v);
    return ASCII_0 + 8'(v / 6'd10);
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [5:0] v);
    return ASCII_0 + 8'(v % 6'd10);
  endfunction

  // Character idx of "HH:MM:SS"; values are shown unclamped (63 -> "63").
  function automatic logic [7:0] time_char(input logic [2:0] idx, input logic [4:0] h,
                                           input logic [5:0] m, input logic [5:0] s);
    case (idx)
      3'd0:    return ascii_tens({1'b0, h});
      3'd1:    return ascii_ones({1'b0, h});
      3'd3:    return ascii_tens(m);
      3'd4:    return ascii_ones(m);
      3'd6:    return ascii_tens(s);
      3'd7:    return ascii_ones(s);
      default: return ASCII_COLON;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_time_display_if.sv
// ----------------------------------------------------------------------------
// lcd_time_display_if: time-of-day inputs, LCD pins and status flags. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lcd_time_display_if;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       frame_done;

  modport master (output hour, min, sec,
                  input  lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done);
  modport slave  (input  hour, min, sec,
                  output lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done);
endinterface

`default_nettype wire

// File: rtl/lcd_bus_write.sv
// ----------------------------------------------------------------------------
// lcd_bus_write: one LCD write transaction (setup, E strobe, hold/wait). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lcd_bus_write
  import lcd_pkg::*;
#(
  parameter int E_HIGH_CYC   = 27,
  parameter int CMD_WAIT_CYC = 2700,
  parameter int CLR_WAIT_CYC = 108000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int MAXW = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int MAXC = (MAXW > E_HIGH_CYC) ? MAXW : E_HIGH_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  bus_phase_e    phase_q;
  logic [CW-1:0] cnt_q;
  logic          long_q;
  logic          w_last;
  logic          w_accept;
  logic [CW-1:0] w_wait_len;

  assign w_last     = (cnt_q == '0);
  assign w_wait_len = long_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  // A new request is taken in the final wait cycle so transactions run back-to-back.
  assign w_accept   = start && ((phase_q == PH_IDLE) || ((phase_q == PH_WAIT) && w_last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        phase_q  <= PH_SETUP;
        lcd_rs   <= rs;
        lcd_data <= data;
        long_q   <= long_wait;
        lcd_e    <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (phase_q)
          PH_SETUP: begin
            phase_q <= PH_STROBE;
            lcd_e   <= 1'b1;
            cnt_q   <= CW'(E_HIGH_CYC - 1);
          end
          PH_STROBE: begin
            if (w_last) begin
              phase_q <= PH_WAIT;
              lcd_e   <= 1'b0;
              cnt_q   <= w_wait_len;
              done    <= (w_wait_len == '0);
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          PH_WAIT: begin
            if (w_last) begin
              phase_q <= PH_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
              done  <= (cnt_q == CW'(1));
            end
          end
          default: phase_q <= PH_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_time_display.sv
// ----------------------------------------------------------------------------
// lcd_time_display: HD44780 init then endless "HH:MM:SS" refresh of line 1. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lcd_time_display
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 1080000,
  parameter int E_HIGH_CYC   = 27,
  parameter int CMD_WAIT_CYC = 2700,
  parameter int CLR_WAIT_CYC = 108000
) (
  input logic               clk,
  input logic               reset,
  lcd_time_display_if.slave bus
);

  localparam int PW = $clog2(PWRUP_CYC + 1);

  lcd_state_e    state_q;
  logic [PW-1:0] pwr_cnt_q;
  logic [2:0]    idx_q;
  logic          init_done_q;
  logic [4:0]    hour_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;

  logic          w_pwr_last;
  logic          w_start;
  logic          w_rs;
  logic          w_long;
  logic [7:0]    w_data;
  logic          w_done;

  assign w_pwr_last = (pwr_cnt_q == PW'(PWRUP_CYC - 1));

  // state_q/idx_q name the transaction offered next; it is taken when the
  // running one signals done (or at the end of power-up for the first one).
  always_comb begin
    w_start = w_done;
    w_rs    = 1'b0;
    w_long  = 1'b0;
    w_data  = LCD_FUNC_SET;
    case (state_q)
      ST_PWRUP: begin
        w_start = w_pwr_last;
        w_data  = init_cmd(3'd0);
      end
      ST_INIT: begin
        w_data = init_cmd(idx_q);
        w_long = (idx_q == 3'd2);
      end
      ST_ADDR: w_data = LCD_DDRAM0;
      ST_CHAR: begin
        w_rs   = 1'b1;
        w_data = time_char(idx_q, hour_q, min_q, sec_q);
      end
      default: w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PWRUP;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
    end else begin
      case (state_q)
        ST_PWRUP: begin
          if (w_pwr_last) begin
            state_q <= ST_INIT;
            idx_q   <= 3'd1;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 1'b1;
          end
        end
        ST_INIT: begin
          if (w_done) begin
            if (idx_q == 3'd3) state_q <= ST_ADDR;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        ST_ADDR: begin
          if (w_done) begin
            hour_q      <= bus.hour;
            min_q       <= bus.min;
            sec_q       <= bus.sec;
            init_done_q <= 1'b1;
            idx_q       <= 3'd0;
            state_q     <= ST_CHAR;
          end
        end
        ST_CHAR: begin
          if (w_done) begin
            if (idx_q == 3'd7) state_q <= ST_ADDR;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  lcd_bus_write #(
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_bus_write (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .rs       (w_rs),
    .data     (w_data),
    .long_wait(w_long),
    .lcd_rs   (bus.lcd_rs),
    .lcd_e    (bus.lcd_e),
    .lcd_data (bus.lcd_data),
    .done     (w_done)
  );

  // In ADDR with init complete, the finishing transaction is character 7.
  assign bus.frame_done = w_done && (state_q == ST_ADDR) && init_done_q;
  assign bus.init_done  = init_done_q;
  assign bus.lcd_rw     = 1'b0;

endmodule

`default_nettype wire
